base2ascii_packer: RTL and testbench
====================================

Name: base2ascii_packer

Overview:
- Reverse of the ASCII-to-parameter front end of the GACT array.
- Takes a handshaked stream of 3-bit nucleotide codes, e.g. from the traceback or reference-fetch logic.
- Converts each code back to an ASCII character, with upper or lower case selected by a per-base soft-mask bit.
- Packs the characters little-endian into BYTES_PER_WORD-wide words for the host/DRAM write path, with byte-keep and last flags.

Parameters:
- BYTES_PER_WORD, 8: ASCII characters per output word; legal range 2..64.
- CNT_WIDTH, 32: width of the emitted-word and N-base counters.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- in_base  in  3  base code: 0=A, 1=C, 2=G, 3=T, 4..7=N.
- in_mask  in  1  1 = soft-masked base, emitted lowercase.
- in_last  in  1  last base of the sequence; forces a flush.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  8*BYTES_PER_WORD  packed ASCII; the first base is in bits [7:0].
- out_keep  out  BYTES_PER_WORD  bit i = 1 when byte i holds a character.
- out_last  out  1  word ends the sequence.
- words_out  out  CNT_WIDTH  words accepted downstream since reset.
- n_count  out  CNT_WIDTH  beats accepted with in_base >= 4 since reset.

Behaviour:
- Reset (async assert, sync release), all state cleared:
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - fill=0, accumulator=0.
  - words_out=0, n_count=0.
- Character mapping, unmasked / masked:
  - 0 -> 0x41 / 0x61
  - 1 -> 0x43 / 0x63
  - 2 -> 0x47 / 0x67
  - 3 -> 0x54 / 0x74
  - 4..7 -> 0x4E / 0x6E
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready; it is combinational from out_ready only, never from in_valid.
- Accumulator and fill:
  - The accepted character is written to accumulator byte [fill]; fill increments.
  - fill counts 0..BYTES_PER_WORD-1 and needs clog2(BYTES_PER_WORD)+1 bits.
- Word completion happens when the accepted beat fills byte BYTES_PER_WORD-1 or carries in_last. On the next edge:
  - out_data = accumulator including the new byte.
  - out_keep = bits [0..fill] set (fill is the value before the increment).
  - out_last = in_last.
  - out_valid = 1.
  - Accumulator and fill clear to 0.
  - Unused bytes of a partial word are 0x00.
- Latency: a completing beat produces its word on out_valid exactly one cycle later.
- Throughput: one beat per cycle while out_ready stays 1.
- Output hold: while out_valid && !out_ready, out_data, out_keep and out_last hold stable.
  - Non-completing beats may still be accepted in this state only if in_ready=1, and by definition in_ready=0 here. The input therefore stalls fully.
- Simultaneous events:
  - out_valid && out_ready && completing beat in the same cycle: the old word retires, the new word loads, and out_valid stays 1.
  - Same case without a completing beat: out_valid goes to 0.
- Back-to-back last beats, each with in_last=1: one word per beat, each with out_keep=0x01.
- in_last on a beat that also fills the word: a single word with all keep bits set and out_last=1. No empty extra word is produced.
- Counters:
  - words_out increments on each out_valid && out_ready.
  - n_count increments on each accepted beat with in_base>=4.
  - Both wrap modulo 2^CNT_WIDTH without saturating.
- rst_n asserted mid-word or mid-stall: the partial accumulator and any pending output word are discarded, and no word is emitted after release.
- in_base/in_mask are ignored when no beat is accepted.

Test Plan (BYTES_PER_WORD=4):
- Full word, out_ready=1, bases 0,1,2,3, mask 0, last on the 4th beat:
  - out_data=0x54474341, keep=0xF, last=1.
  - out_valid is high one cycle after the 4th beat.
- Soft mask and N, bases 4,0,7 with mask 1,0,1 and last on the 3rd beat:
  - out_data=0x006E416E, keep=0x7, last=1, n_count=2.
- Backpressure:
  - Stimulus: 8 beats with no last on any beat, out_ready=0 until cycle 10.
  - Required: in_ready=0 after the first word, word 1 held stable, the second word follows, words_out=2, no beat lost.
- Streaming, out_ready=1:
  - Stimulus: 12 continuous beats with in_valid=1 every cycle.
  - Required: in_ready constantly 1, 3 words on consecutive 4-cycle boundaries.
- Reset mid-word:
  - Stimulus: 2 beats accepted, then rst_n pulsed low asynchronously between edges.
  - Required: outputs are 0 immediately.
  - Required, after release: the next 4 beats form a clean word with no residue of the earlier beats.
- Single-base sequences: three beats, each with last=1, out_ready=1 → three words with keep=0x1 and last=1.

Source files
------------

// File: rtl/base2ascii_packer.sv
// Converts a handshaked stream of 3-bit nucleotide codes into ASCII characters.
// Packs the characters little-endian into BYTES_PER_WORD-wide words with keep/last flags.
module base2ascii_packer #(
    parameter int BYTES_PER_WORD = 8,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_base,
    input  logic                        in_mask,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]   out_keep,
    output logic                        out_last,
    output logic [CNT_WIDTH-1:0]        words_out,
    output logic [CNT_WIDTH-1:0]        n_count
);

    localparam int FW = $clog2(BYTES_PER_WORD) + 1;
    localparam int DW = 8 * BYTES_PER_WORD;
    localparam logic [FW-1:0] LAST_IDX = FW'(BYTES_PER_WORD - 1);

    // Soft-masked bases become lowercase by setting ASCII bit 5.
    function automatic logic [7:0] base_to_ascii(input logic [2:0] base, input logic mask);
        logic [7:0] c;
        case (base)
            3'd0:    c = 8'h41;
            3'd1:    c = 8'h43;
            3'd2:    c = 8'h47;
            3'd3:    c = 8'h54;
            default: c = 8'h4E;
        endcase
        return mask ? (c | 8'h20) : c;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic [BYTES_PER_WORD-1:0] out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic [DW-1:0]        acc_q, acc_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [CNT_WIDTH-1:0] words_q, words_d;
    logic [CNT_WIDTH-1:0] ncnt_q, ncnt_d;

    logic                 accept_s;
    logic                 complete_s;
    logic [7:0]           char_s;
    logic [DW-1:0]        acc_new_s;
    logic [BYTES_PER_WORD-1:0] keep_new_s;

    assign in_ready = !out_valid_q || out_ready;

    // Accumulator merge and next-state for the output word, fill and counters.
    always_comb begin
        accept_s   = in_valid && in_ready;
        complete_s = accept_s && ((fill_q == LAST_IDX) || in_last);
        char_s     = base_to_ascii(in_base, in_mask);
        acc_new_s  = acc_q;
        keep_new_s = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (fill_q == FW'(i)) begin
                acc_new_s[8*i +: 8] = char_s;
            end else begin
                acc_new_s[8*i +: 8] = acc_q[8*i +: 8];
            end
            keep_new_s[i] = (FW'(i) <= fill_q);
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        acc_d       = acc_q;
        fill_d      = fill_q;

        if (complete_s) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_new_s;
            out_keep_d  = keep_new_s;
            out_last_d  = in_last;
            acc_d       = '0;
            fill_d      = '0;
        end else if (accept_s) begin
            out_valid_d = out_valid_q && !out_ready;
            acc_d       = acc_new_s;
            fill_d      = fill_q + FW'(1);
        end else begin
            out_valid_d = out_valid_q && !out_ready;
        end

        if (out_valid_q && out_ready) begin
            words_d = words_q + CNT_WIDTH'(1);
        end else begin
            words_d = words_q;
        end

        if (accept_s && in_base[2]) begin
            ncnt_d = ncnt_q + CNT_WIDTH'(1);
        end else begin
            ncnt_d = ncnt_q;
        end
    end

    // State registers; reset discards any partial or pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
            fill_q      <= '0;
            words_q     <= '0;
            ncnt_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            words_q     <= words_d;
            ncnt_q      <= ncnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign words_out = words_q;
    assign n_count   = ncnt_q;

endmodule

// File: tb/tb_base2ascii_packer.sv
// Self-checking bench for base2ascii_packer with 4 bytes per word.
// Uses a vector table, directed multi-cycle sequences and random traffic against a reference model.
module tb_base2ascii_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_base;
    logic        in_mask;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [31:0] words_out;
    logic [31:0] n_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending output word, character buffer, counters.
    logic        mv;
    logic [31:0] md;
    logic [3:0]  mk;
    logic        ml;
    logic [31:0] mw;
    logic [31:0] mn;
    logic [7:0]  mbuf [4];
    int          mfill;

    always #5 clk = ~clk;

    base2ascii_packer #(.BYTES_PER_WORD(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .words_out(words_out), .n_count(n_count)
    );

    typedef struct {
        logic        v;
        logic [2:0]  b;
        logic        m;
        logic        l;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic [31:0] ew;
        logic [31:0] en;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic [2:0] b, input logic m);
        string s;
        logic [7:0] c;
        s = "ACGTNNNN";
        c = s[b];
        return m ? c + 8'd32 : c;
    endfunction

    task automatic model_reset();
        mv = 1'b0; md = 32'h0; mk = 4'h0; ml = 1'b0;
        mw = 32'h0; mn = 32'h0; mfill = 0;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] b, input logic m, input logic l, input logic r);
        logic acc;
        logic done;
        acc  = v && (!mv || r);
        done = 1'b0;
        if (mv && r) mw = mw + 32'd1;
        if (acc && b >= 3'd4) mn = mn + 32'd1;
        if (acc) begin
            mbuf[mfill] = ref_char(b, m);
            mfill++;
            if (mfill == 4 || l) begin
                done = 1'b1;
                md = 32'h0;
                for (int i = 0; i < mfill; i++) md = md | (32'(mbuf[i]) << (8 * i));
                mk = 4'((1 << mfill) - 1);
                ml = l;
                mfill = 0;
            end
        end
        if (done) mv = 1'b1;
        else if (mv && r) mv = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [2:0] b, input logic m, input logic l, input logic r);
        in_valid = v; in_base = b; in_mask = m; in_last = l; out_ready = r;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!mv || r));
        model_edge(v, b, m, l, r);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(mv));
        if (mv) begin
            chk("out_data", out_data, md);
            chk("out_keep", 32'(out_keep), 32'(mk));
            chk("out_last", 32'(out_last), 32'(ml));
        end
        chk("words_out", words_out, mw);
        chk("n_count", n_count, mn);
    endtask

    initial begin
        logic [2:0] bp_b [8];
        int         k;
        logic       r;
        logic [31:0] w0;

        tbl[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd0, 32'd0};
        tbl[1]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd0, 32'd0};
        tbl[2]  = '{1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd0, 32'd0};
        tbl[3]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h54474341, 4'hF, 1'b1, 32'd0, 32'd0};
        tbl[4]  = '{1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd1, 32'd1};
        tbl[5]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd1, 32'd1};
        tbl[6]  = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h006E416E, 4'h7, 1'b1, 32'd1, 32'd2};
        tbl[7]  = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000043, 4'h1, 1'b1, 32'd2, 32'd2};
        tbl[8]  = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000047, 4'h1, 1'b1, 32'd3, 32'd2};
        tbl[9]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000054, 4'h1, 1'b1, 32'd4, 32'd2};
        tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd5, 32'd2};

        rst_n = 1'b0; in_valid = 1'b0; in_base = 3'd0; in_mask = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_keep", 32'(out_keep), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_words", words_out, 32'd0);
        chk("rst_ncount", n_count, 32'd0);

        // Table: full word, soft mask with N, then single-base sequences.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].m, tbl[i].l, tbl[i].r);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_data", out_data, tbl[i].ed);
                chk("tbl_keep", 32'(out_keep), 32'(tbl[i].ek));
                chk("tbl_last", 32'(out_last), 32'(tbl[i].el));
            end
            chk("tbl_words", words_out, tbl[i].ew);
            chk("tbl_ncount", n_count, tbl[i].en);
        end

        // Backpressure: out_ready low until cycle 10, 8 beats without last.
        bp_b[0] = 3'd1; bp_b[1] = 3'd1; bp_b[2] = 3'd2; bp_b[3] = 3'd2;
        bp_b[4] = 3'd3; bp_b[5] = 3'd0; bp_b[6] = 3'd4; bp_b[7] = 3'd0;
        k  = 0;
        w0 = mw;
        for (int c = 0; c < 18; c++) begin
            r = (c >= 10);
            if (k < 8) begin
                if (!mv || r) begin
                    cycle(1'b1, bp_b[k], 1'b0, 1'b0, r);
                    k++;
                end else begin
                    cycle(1'b1, bp_b[k], 1'b0, 1'b0, r);
                end
            end else begin
                cycle(1'b0, 3'd0, 1'b0, 1'b0, r);
            end
            if (c >= 3 && c <= 9) begin
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_hold", out_data, 32'h47474343);
            end
            if (c == 13) chk("bp_word2", out_data, 32'h414E4154);
        end
        chk("bp_words", words_out, w0 + 32'd2);
        chk("bp_beats", 32'(k), 32'd8);

        // Streaming: 12 continuous beats, words on every 4th edge.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 3'(i % 4), 1'b0, 1'b0, 1'b1);
            chk("stream_ready", 32'(in_ready), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'((i % 4) == 3));
        end
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word: two beats, asynchronous reset between edges.
        cycle(1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_keep", 32'(out_keep), 32'd0);
        chk("mid_rst_words", words_out, 32'd0);
        chk("mid_rst_ncount", n_count, 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
        chk("post_rst_data", out_data, 32'h54545454);
        chk("post_rst_keep", 32'(out_keep), 32'hF);
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
        end
        repeat (3) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
